// File: rtl/aib_test_agent.sv
// AIB link-test agent: streams an 8-word pattern loop on TX, aligns to it on RX and checks every returned word.
// Start/abort act two cycles after i_en changes; one word per cycle each way, no backpressure.
module aib_test_agent #(
    parameter int unsigned TimeoutCyc = 1024
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic [15:0]      i_loop_cnt,
    input  logic [7:0][19:0] i_pattern0,
    input  logic [7:0][19:0] i_pattern1,
    output logic [19:0]      o_tx_data0,
    output logic [19:0]      o_tx_data1,
    input  logic [19:0]      i_rx_data0,
    input  logic [19:0]      i_rx_data1,
    output logic             o_test_pass,
    output logic             o_test_fail,
    output logic             o_test_timeout,
    output logic [15:0]      o_fail_cnt,
    output logic [19:0]      o_fail_data0,
    output logic [19:0]      o_fail_data1
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ALIGN,
        ST_CHECK,
        ST_DONE
    } state_e;

    localparam logic [15:0] TimeoutLast = 16'(TimeoutCyc - 1);

    state_e      state_q, state_d;
    logic        en_meta_q, en_s_q, en_prev_q;
    logic [1:0]  sync_vld_q;
    logic        start_blk_q, start_blk_d;
    logic [2:0]  tx_idx_q, tx_idx_d;
    logic [2:0]  rx_idx_q, rx_idx_d;
    logic [15:0] loop_idx_q, loop_idx_d;
    logic [15:0] cyc_q, cyc_d;
    logic [19:0] tx0_q, tx0_d, tx1_q, tx1_d;
    logic        pass_q, pass_d, fail_q, fail_d, timeout_q, timeout_d;
    logic [15:0] fail_cnt_q, fail_cnt_d;
    logic [19:0] fail_data0_q, fail_data0_d, fail_data1_q, fail_data1_d;

    logic        start;
    logic        rx_match;
    logic [15:0] loop_last;

    // After reset, en_s must be seen low once before a rising edge counts, so an
    // enable held high across reset cannot relaunch the run.
    assign start       = en_s_q & ~en_prev_q & ~start_blk_q;
    assign start_blk_d = start_blk_q & ~(sync_vld_q[1] & ~en_s_q);
    assign loop_last   = (i_loop_cnt == 16'd0) ? 16'd0 : i_loop_cnt - 16'd1;
    assign rx_match    = (i_rx_data0 == i_pattern0[rx_idx_q]) &&
                         (i_rx_data1 == i_pattern1[rx_idx_q]);

    always_comb begin
        state_d      = state_q;
        tx_idx_d     = 3'd0;
        rx_idx_d     = rx_idx_q;
        loop_idx_d   = loop_idx_q;
        cyc_d        = cyc_q;
        tx0_d        = 20'd0;
        tx1_d        = 20'd0;
        pass_d       = pass_q;
        fail_d       = fail_q;
        timeout_d    = timeout_q;
        fail_cnt_d   = fail_cnt_q;
        fail_data0_d = fail_data0_q;
        fail_data1_d = fail_data1_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d      = ST_ALIGN;
                    rx_idx_d     = 3'd0;
                    loop_idx_d   = 16'd0;
                    cyc_d        = 16'd0;
                    pass_d       = 1'b0;
                    fail_d       = 1'b0;
                    timeout_d    = 1'b0;
                    fail_cnt_d   = 16'd0;
                    fail_data0_d = 20'd0;
                    fail_data1_d = 20'd0;
                end
            end
            ST_ALIGN: begin
                cyc_d = cyc_q + 16'd1;
                if (!en_s_q) begin
                    state_d = ST_IDLE;
                end else if (rx_match) begin
                    state_d  = ST_CHECK;
                    rx_idx_d = 3'd1;
                end else if (cyc_q == TimeoutLast) begin
                    state_d   = ST_DONE;
                    timeout_d = 1'b1;
                end
            end
            ST_CHECK: begin
                if (!en_s_q) begin
                    state_d = ST_IDLE;
                end else begin
                    if (!rx_match) begin
                        if (fail_cnt_q != 16'hFFFF) begin
                            fail_cnt_d = fail_cnt_q + 16'd1;
                        end
                        if (fail_cnt_q == 16'd0) begin
                            fail_data0_d = i_rx_data0;
                            fail_data1_d = i_rx_data1;
                        end
                    end
                    rx_idx_d = rx_idx_q + 3'd1;
                    // The last word's compare is already folded into fail_cnt_d here.
                    if (rx_idx_q == 3'd7) begin
                        if (loop_idx_q == loop_last) begin
                            state_d = ST_DONE;
                            pass_d  = (fail_cnt_d == 16'd0);
                            fail_d  = (fail_cnt_d != 16'd0);
                        end else begin
                            loop_idx_d = loop_idx_q + 16'd1;
                        end
                    end
                end
            end
            ST_DONE: begin
                if (!en_s_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_d == ST_ALIGN || state_d == ST_CHECK) begin
            tx0_d    = i_pattern0[tx_idx_q];
            tx1_d    = i_pattern1[tx_idx_q];
            tx_idx_d = tx_idx_q + 3'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= ST_IDLE;
            en_meta_q    <= 1'b0;
            en_s_q       <= 1'b0;
            en_prev_q    <= 1'b0;
            sync_vld_q   <= 2'b00;
            start_blk_q  <= 1'b1;
            tx_idx_q     <= 3'd0;
            rx_idx_q     <= 3'd0;
            loop_idx_q   <= 16'd0;
            cyc_q        <= 16'd0;
            tx0_q        <= 20'd0;
            tx1_q        <= 20'd0;
            pass_q       <= 1'b0;
            fail_q       <= 1'b0;
            timeout_q    <= 1'b0;
            fail_cnt_q   <= 16'd0;
            fail_data0_q <= 20'd0;
            fail_data1_q <= 20'd0;
        end else begin
            state_q      <= state_d;
            en_meta_q    <= i_en;
            en_s_q       <= en_meta_q;
            en_prev_q    <= en_s_q;
            sync_vld_q   <= {sync_vld_q[0], 1'b1};
            start_blk_q  <= start_blk_d;
            tx_idx_q     <= tx_idx_d;
            rx_idx_q     <= rx_idx_d;
            loop_idx_q   <= loop_idx_d;
            cyc_q        <= cyc_d;
            tx0_q        <= tx0_d;
            tx1_q        <= tx1_d;
            pass_q       <= pass_d;
            fail_q       <= fail_d;
            timeout_q    <= timeout_d;
            fail_cnt_q   <= fail_cnt_d;
            fail_data0_q <= fail_data0_d;
            fail_data1_q <= fail_data1_d;
        end
    end

    assign o_tx_data0     = tx0_q;
    assign o_tx_data1     = tx1_q;
    assign o_test_pass    = pass_q;
    assign o_test_fail    = fail_q;
    assign o_test_timeout = timeout_q;
    assign o_fail_cnt     = fail_cnt_q;
    assign o_fail_data0   = fail_data0_q;
    assign o_fail_data1   = fail_data1_q;

endmodule
